// File: rtl/divisor_secuencial.sv
// divisor_secuencial: restoring unsigned divider, one quotient bit per clock, start/listo handshake.
// restador_N_bits is the shared borrow-output subtractor: {co, rest} = a - b - ci.
module restador_N_bits #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic [N-1:0] rest,
   output logic         co
);
   assign {co, rest} = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, ci};
endmodule

module divisor_secuencial #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividendo,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] cociente,
   output logic [N-1:0] residuo,
   output logic         listo,
   output logic         ocupado,
   output logic         div_cero
);
   localparam int CW = $clog2(N + 1);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t        state_q;
   logic [N-1:0]  r_q, q_q, d_q, r_d, q_d;
   logic [CW-1:0] cnt_q;
   logic [N:0]    s, rest;
   logic          co, unused_msb;
   assign s = {r_q, q_q[N-1]};
   restador_N_bits #(.N(N + 1)) u_res (
      .a   (s),
      .b   ({1'b0, d_q}),
      .ci  (1'b0),
      .rest(rest),
      .co  (co)
   );
   // A non-borrowing difference is below D, so its top bit is always zero.
   assign unused_msb = rest[N];
   assign r_d = co ? s[N-1:0] : rest[N-1:0];
   assign q_d = {q_q[N-2:0], ~co};
   assign listo = state_q == DONE;
   assign ocupado = state_q != IDLE;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= IDLE;
         r_q      <= '0;
         q_q      <= '0;
         d_q      <= '0;
         cnt_q    <= '0;
         cociente <= '0;
         residuo  <= '0;
         div_cero <= 1'b0;
      end else
         case (state_q)
            IDLE: if (start) begin
               if (divisor == '0) begin
                  state_q  <= DONE;
                  cociente <= '1;
                  residuo  <= dividendo;
                  div_cero <= 1'b1;
               end else begin
                  state_q <= CALC;
                  r_q     <= '0;
                  q_q     <= dividendo;
                  d_q     <= divisor;
                  cnt_q   <= '0;
               end
            end
            CALC: begin
               r_q   <= r_d;
               q_q   <= q_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  state_q  <= DONE;
                  cociente <= q_d;
                  residuo  <= r_d;
                  div_cero <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
endmodule

// File: tb/tb_divisor_secuencial.sv
// tb_divisor_secuencial: directed N=4 and randomized N=8 checks against an arithmetic reference model.
module tb_divisor_secuencial;
   logic clk = 1'b0, rst = 1'b1;
   logic st4 = 1'b0, st8 = 1'b0;
   logic [3:0] dd4 = '0, dv4 = '0, q4, r4;
   logic [7:0] dd8 = '0, dv8 = '0, q8, r8;
   logic l4, o4, z4, l8, o8, z8;
   int n_chk = 0, n_err = 0;
   int prev_q [2] = '{0, 0};
   int prev_dz [2] = '{0, 0};
   time last_acc [2];

   always #5 clk = ~clk;

   divisor_secuencial #(.N(4)) u4 (.clk(clk), .rst(rst), .start(st4), .dividendo(dd4), .divisor(dv4),
      .cociente(q4), .residuo(r4), .listo(l4), .ocupado(o4), .div_cero(z4));
   divisor_secuencial #(.N(8)) u8 (.clk(clk), .rst(rst), .start(st8), .dividendo(dd8), .divisor(dv8),
      .cociente(q8), .residuo(r8), .listo(l8), .ocupado(o8), .div_cero(z8));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gq(input bit s); return s ? q8 : {4'b0, q4}; endfunction
   function automatic logic [7:0] gr(input bit s); return s ? r8 : {4'b0, r4}; endfunction
   function automatic logic gl(input bit s); return s ? l8 : l4; endfunction
   function automatic logic go(input bit s); return s ? o8 : o4; endfunction
   function automatic logic gz(input bit s); return s ? z8 : z4; endfunction

   task automatic drive(input bit s, input logic st, input int dd, input int dv);
      if (s) begin st8 = st; dd8 = 8'(dd); dv8 = 8'(dv); end
      else begin st4 = st; dd4 = 4'(dd); dv4 = 4'(dv); end
   endtask

   // Call at a negedge with the DUT idle; returns one cycle after the DUT is back in IDLE.
   task automatic do_op(input bit s, input int dd, input int dv, input bit b2b);
      int n = s ? 8 : 4;
      int mx = s ? 255 : 15;
      int eq = dv == 0 ? mx : dd / dv;
      int er = dv == 0 ? dd : dd % dv;
      int lat = 0;
      drive(s, 1'b1, dd, dv);
      @(posedge clk);
      if (b2b) check("spacing", 64'($time - last_acc[s]), 64'((prev_dz[s] != 0 ? 2 : n + 2) * 10));
      last_acc[s] = $time;
      #1 drive(s, 1'b0, $urandom, $urandom);
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1 && !gl(s)) begin
            check("hold_q", 64'(gq(s)), 64'(prev_q[s]));
            check("busy", 64'(go(s)), 64'd1);
         end
      end while (!gl(s) && lat < 40);
      check("latency", 64'(lat), 64'(dv == 0 ? 1 : n + 1));
      check("cociente", 64'(gq(s)), 64'(eq));
      check("residuo", 64'(gr(s)), 64'(er));
      check("div_cero", 64'(gz(s)), 64'(dv == 0));
      check("busy_done", 64'(go(s)), 64'd1);
      prev_q[s] = eq;
      prev_dz[s] = dv == 0 ? 1 : 0;
      @(posedge clk);
      @(negedge clk);
      check("idle", 64'({gl(s), go(s)}), 64'd0);
   endtask

   initial begin
      int cnt;
      int dd, dv;
      #1;
      check("rst_q", 64'({q4, r4, l4, o4, z4}), 64'd0);
      check("rst_q8", 64'({q8, r8, l8, o8, z8}), 64'd0);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      do_op(0, 13, 3, 0);
      do_op(0, 15, 1, 0);
      do_op(0, 7, 9, 0);
      do_op(0, 15, 15, 0);
      do_op(0, 0, 5, 0);
      do_op(0, 9, 0, 0);
      do_op(0, 8, 2, 0);
      // start pulses with other operands during CALC and DONE must be ignored
      drive(0, 1'b1, 13, 3);
      @(posedge clk);
      #1 drive(0, 1'b1, 2, 1);
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!l4 && cnt < 20);
      check("ign_lat", 64'(cnt), 64'd5);
      check("ign_q", 64'(q4), 64'd4);
      check("ign_r", 64'(r4), 64'd1);
      @(posedge clk);
      #1 drive(0, 1'b0, 0, 0);
      cnt = 0;
      repeat (12) begin @(negedge clk); cnt += int'(l4); end
      check("no_2nd_listo", 64'(cnt), 64'd0);
      check("ign_keep_q", 64'({q4, r4}), 64'({4'd4, 4'd1}));
      // asynchronous reset between edges in the middle of CALC
      drive(0, 1'b1, 13, 3);
      @(posedge clk);
      #1 drive(0, 1'b0, 0, 0);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_out", 64'({q4, r4, l4, o4, z4}), 64'd0);
      @(negedge clk) rst = 1'b0;
      prev_q[0] = 0;
      cnt = 0;
      repeat (8) begin @(negedge clk); cnt += int'(l4); end
      check("arst_no_listo", 64'(cnt), 64'd0);
      do_op(0, 11, 4, 0);
      // N=8 randomized back-to-back run
      do_op(1, 255, 0, 0);
      do_op(1, 0, 255, 1);
      for (int i = 0; i < 1000; i++) begin
         dd = int'($urandom_range(0, 255));
         case ($urandom_range(0, 9))
            0: dv = 0;
            1: dv = 255;
            default: dv = int'($urandom_range(0, 255));
         endcase
         do_op(1, dd, dv, 1);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
